// File: rtl/mfm_sync_deserializer.sv
// ---------------------------------------------------------------------------
// mfm_sync_deserializer
//
// Consumes the raw MFM channel-bit stream recovered by digital_pll, hunts for
// the A1 sync word (0x4489, missing clock), aligns to the cell boundary after
// it, and decodes the following cells into bytes for the sector/field parser.
// The byte after a run of SYNC_COUNT A1 words is flagged as the address mark.
// Clock bits of the mark and of every data byte are checked for MFM legality.
//
// Optional build feature:
//   MFM_CRC_EN - adds crc_value/crc_ok, a CRC-16-CCITT (0x1021, init 0xFFFF)
//                running over the A1 bytes, the mark byte and the data bytes.
//
// Ports:
//   clk         in   system clock (shared with digital_pll)
//   reset_n     in   asynchronous active-low reset
//   enable      in   block enable; low forces HUNT
//   resync      in   single-cycle pulse; abandon the field and return to HUNT
//   pll_locked  in   lock status from digital_pll; low forces HUNT
//   data_bit    in   raw MFM channel bit
//   data_ready  in   single-cycle strobe qualifying data_bit
//   byte_out    out  [7:0] decoded byte
//   byte_valid  out  single-cycle strobe for byte_out
//   is_mark     out  qualifies byte_valid: byte is the address mark
//   sync_pulse  out  single-cycle pulse on each aligned sync-word match
//   in_sync     out  high while in SYNC or DATA
//   mfm_error   out  single-cycle pulse (with byte_valid) on a clock violation
//   byte_count  out  [10:0] bytes output since the mark, mark included
//   crc_value   out  [15:0] running CRC            (MFM_CRC_EN only)
//   crc_ok      out  crc_value is zero while in DATA (MFM_CRC_EN only)
//
// State table:
//   state   | meaning
//   HUNT    | sliding search for the sync word after every shifted bit
//   SYNC    | word-aligned inside an A1 run, counting consecutive A1s
//   DATA    | decoding bytes after the address mark
// ---------------------------------------------------------------------------
module mfm_sync_deserializer #(
    parameter logic [15:0] SYNC_WORD  = 16'h4489,
    parameter int          SYNC_COUNT = 3,
    parameter int          MAX_BYTES  = 1100
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        resync,
    input  logic        pll_locked,
    input  logic        data_bit,
    input  logic        data_ready,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    output logic        is_mark,
    output logic        sync_pulse,
    output logic        in_sync,
    output logic        mfm_error,
    output logic [10:0] byte_count
`ifdef MFM_CRC_EN
    ,
    output logic [15:0] crc_value,
    output logic        crc_ok
`endif
);

    localparam int          A1W      = $clog2(SYNC_COUNT + 1);
    localparam logic [A1W-1:0] A1_FULL = A1W'(SYNC_COUNT);
    localparam logic [10:0] MAX_CNT  = 11'(MAX_BYTES);

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_SYNC = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t         state, state_d;
    logic [15:0]    raw, raw_d;
    logic [3:0]     bitcnt, bitcnt_d;
    logic [A1W-1:0] a1_cnt, a1_cnt_d;
    logic           prev_d, prev_d_d;
    logic [10:0]    byte_count_d;
    logic [7:0]     byte_out_d;
    logic           byte_valid_d, is_mark_d, sync_pulse_d, mfm_error_d;

    logic           abort;
    logic           shift;
    logic [15:0]    raw_sh;
    logic           is_sync;
    logic [7:0]     dec_byte;
    logic           clk_bad;

`ifdef MFM_CRC_EN
    logic [15:0]    crc_q, crc_d;

    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in,
                                               input logic [7:0]  b);
        logic [15:0] c;
        logic        fb;
        c = crc_in;
        for (int i = 7; i >= 0; i--) begin
            fb = c[15] ^ b[i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction
`endif

    // Each cell is {clock, data}; the first cell sits in raw[15:14]. A legal
    // clock bit is 1 only between two zero data bits, and the previous data
    // bit carries in from the preceding byte.
    function automatic logic clock_bad(input logic [15:0] w, input logic prev);
        logic p;
        logic bad;
        p   = prev;
        bad = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (w[2*i+1] != (~p & ~w[2*i])) bad = 1'b1;
            p = w[2*i];
        end
        return bad;
    endfunction

    assign abort    = ~enable | ~pll_locked | resync;
    assign shift    = data_ready & ~abort;
    assign raw_sh   = {raw[14:0], data_bit};
    assign is_sync  = (raw_sh == SYNC_WORD);
    assign dec_byte = {raw_sh[14], raw_sh[12], raw_sh[10], raw_sh[8],
                       raw_sh[6],  raw_sh[4],  raw_sh[2],  raw_sh[0]};
    assign clk_bad  = clock_bad(raw_sh, prev_d);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_HUNT;
            raw        <= 16'h0000;
            bitcnt     <= 4'd0;
            a1_cnt     <= '0;
            prev_d     <= 1'b0;
            byte_count <= 11'd0;
            byte_out   <= 8'h00;
            byte_valid <= 1'b0;
            is_mark    <= 1'b0;
            sync_pulse <= 1'b0;
            mfm_error  <= 1'b0;
`ifdef MFM_CRC_EN
            crc_q      <= 16'h0000;
`endif
        end else begin
            state      <= state_d;
            raw        <= raw_d;
            bitcnt     <= bitcnt_d;
            a1_cnt     <= a1_cnt_d;
            prev_d     <= prev_d_d;
            byte_count <= byte_count_d;
            byte_out   <= byte_out_d;
            byte_valid <= byte_valid_d;
            is_mark    <= is_mark_d;
            sync_pulse <= sync_pulse_d;
            mfm_error  <= mfm_error_d;
`ifdef MFM_CRC_EN
            crc_q      <= crc_d;
`endif
        end
    end

    always_comb begin
        state_d      = state;
        raw_d        = raw;
        bitcnt_d     = bitcnt;
        a1_cnt_d     = a1_cnt;
        prev_d_d     = prev_d;
        byte_count_d = byte_count;
        byte_out_d   = byte_out;
        byte_valid_d = 1'b0;
        is_mark_d    = 1'b0;
        sync_pulse_d = 1'b0;
        mfm_error_d  = 1'b0;
`ifdef MFM_CRC_EN
        crc_d        = crc_q;
`endif

        if (abort) begin
            // Any bit arriving alongside the abort is dropped on purpose.
            state_d  = ST_HUNT;
            raw_d    = 16'h0000;
            bitcnt_d = 4'd0;
        end else if (shift) begin
            raw_d    = raw_sh;
            bitcnt_d = bitcnt + 4'd1;
            case (state)
                ST_HUNT: begin
                    if (is_sync) begin
                        sync_pulse_d = 1'b1;
                        a1_cnt_d     = A1W'(1);
                        bitcnt_d     = 4'd0;
                        prev_d_d     = 1'b1;
                        state_d      = ST_SYNC;
`ifdef MFM_CRC_EN
                        crc_d        = crc16_byte(16'hFFFF, 8'hA1);
`endif
                    end
                end
                ST_SYNC: begin
                    if (bitcnt == 4'd15) begin
                        if (is_sync) begin
                            sync_pulse_d = 1'b1;
                            prev_d_d     = 1'b1;
                            if (a1_cnt != A1_FULL) a1_cnt_d = a1_cnt + A1W'(1);
`ifdef MFM_CRC_EN
                            crc_d        = crc16_byte(crc_q, 8'hA1);
`endif
                        end else if (a1_cnt == A1_FULL) begin
                            byte_out_d   = dec_byte;
                            byte_valid_d = 1'b1;
                            is_mark_d    = 1'b1;
                            mfm_error_d  = clk_bad;
                            byte_count_d = 11'd1;
                            prev_d_d     = raw_sh[0];
                            state_d      = (MAX_CNT <= 11'd1) ? ST_HUNT : ST_DATA;
`ifdef MFM_CRC_EN
                            crc_d        = crc16_byte(crc_q, dec_byte);
`endif
                        end else begin
                            state_d = ST_HUNT;
                        end
                    end
                end
                ST_DATA: begin
                    if (bitcnt == 4'd15) begin
                        if (is_sync) begin
                            // A fresh A1 run interrupts the field; it starts a new run.
                            sync_pulse_d = 1'b1;
                            a1_cnt_d     = A1W'(1);
                            prev_d_d     = 1'b1;
                            state_d      = ST_SYNC;
`ifdef MFM_CRC_EN
                            crc_d        = crc16_byte(16'hFFFF, 8'hA1);
`endif
                        end else begin
                            byte_out_d   = dec_byte;
                            byte_valid_d = 1'b1;
                            mfm_error_d  = clk_bad;
                            byte_count_d = byte_count + 11'd1;
                            prev_d_d     = raw_sh[0];
                            if ((byte_count + 11'd1) >= MAX_CNT) state_d = ST_HUNT;
`ifdef MFM_CRC_EN
                            crc_d        = crc16_byte(crc_q, dec_byte);
`endif
                        end
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    assign in_sync = (state != ST_HUNT);

`ifdef MFM_CRC_EN
    assign crc_value = crc_q;
    assign crc_ok    = (state == ST_DATA) && (crc_q == 16'h0000);
`endif

endmodule

// File: tb/tb_mfm_sync_deserializer.sv
module tb_mfm_sync_deserializer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        resync;
    logic        pll_locked;
    logic        data_bit;
    logic        data_ready;

    logic [7:0]  byte_out;
    logic        byte_valid, is_mark, sync_pulse, in_sync, mfm_error;
    logic [10:0] byte_count;
    logic [7:0]  b_byte_out;
    logic        b_byte_valid, b_is_mark, b_sync_pulse, b_in_sync, b_mfm_error;
    logic [10:0] b_byte_count;
`ifdef MFM_CRC_EN
    logic [15:0] crc_value, b_crc_value;
    logic        crc_ok, b_crc_ok;
`endif

    int checks   = 0;
    int failures = 0;

    int bv_cnt = 0, sync_cnt = 0, err_cnt = 0, bv_cnt_b = 0;
    logic [9:0] rec_q[$];   // {is_mark, mfm_error, byte_out}
    logic tx_prev = 1'b0;

    mfm_sync_deserializer dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .resync(resync),
        .pll_locked(pll_locked), .data_bit(data_bit), .data_ready(data_ready),
        .byte_out(byte_out), .byte_valid(byte_valid), .is_mark(is_mark),
        .sync_pulse(sync_pulse), .in_sync(in_sync), .mfm_error(mfm_error),
        .byte_count(byte_count)
`ifdef MFM_CRC_EN
        , .crc_value(crc_value), .crc_ok(crc_ok)
`endif
    );

    mfm_sync_deserializer #(.MAX_BYTES(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .enable(enable), .resync(resync),
        .pll_locked(pll_locked), .data_bit(data_bit), .data_ready(data_ready),
        .byte_out(b_byte_out), .byte_valid(b_byte_valid), .is_mark(b_is_mark),
        .sync_pulse(b_sync_pulse), .in_sync(b_in_sync), .mfm_error(b_mfm_error),
        .byte_count(b_byte_count)
`ifdef MFM_CRC_EN
        , .crc_value(b_crc_value), .crc_ok(b_crc_ok)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (byte_valid) begin
            bv_cnt++;
            rec_q.push_back({is_mark, mfm_error, byte_out});
        end
        if (sync_pulse) sync_cnt++;
        if (mfm_error) err_cnt++;
        if (b_byte_valid) bv_cnt_b++;
    end

    function automatic logic [15:0] mfm_enc(input logic [7:0] b, input logic prev);
        logic [15:0] w;
        logic        p;
        p = prev;
        for (int i = 7; i >= 0; i--) begin
            w[2*i]   = b[i];
            w[2*i+1] = ~p & ~b[i];
            p        = b[i];
        end
        return w;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        data_bit   = b;
        data_ready = 1'b1;
        @(negedge clk);
        data_ready = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_word(mfm_enc(b, tx_prev));
        tx_prev = b[0];
    endtask

    task automatic send_sync();
        send_word(16'h4489);
        tx_prev = 1'b1;
    endtask

    task automatic send_preamble(input int n);
        for (int i = 0; i < n; i++) send_byte(8'h00);
    endtask

    task automatic do_resync();
        @(negedge clk);
        resync = 1'b1;
        @(negedge clk);
        resync = 1'b0;
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        enable     = 1'b1;
        resync     = 1'b0;
        pll_locked = 1'b1;
        data_bit   = 1'b0;
        data_ready = 1'b0;
        for (int i = 0; i < 100; i++) send_bit(1'($urandom_range(0, 1)));
        checks++; if (bv_cnt !== 0) begin failures++; $display("FAIL reset_bv_seen got %0d want 0", bv_cnt); end
        checks++; if (sync_cnt !== 0) begin failures++; $display("FAIL reset_sync_seen got %0d want 0", sync_cnt); end
        checks++; if (byte_out !== 8'h00) begin failures++; $display("FAIL reset_byte_out got %0h want 0", byte_out); end
        checks++; if (in_sync !== 1'b0) begin failures++; $display("FAIL reset_in_sync got %0b want 0", in_sync); end
        checks++; if (byte_count !== 11'd0) begin failures++; $display("FAIL reset_byte_count got %0d want 0", byte_count); end
        checks++; if ({byte_valid, is_mark, sync_pulse, mfm_error} !== 4'b0) begin
            failures++; $display("FAIL reset_strobes got %b want 0000", {byte_valid, is_mark, sync_pulse, mfm_error});
        end
`ifdef MFM_CRC_EN
        checks++; if ({crc_value, crc_ok} !== 17'h0) begin failures++; $display("FAIL reset_crc got %0h want 0", {crc_value, crc_ok}); end
`endif
        @(negedge clk);
        reset_n = 1'b1;
        tx_prev = 1'b0;
        idle(2);
    endtask

    task automatic test_normal_field();
        logic [9:0] exp_rec [7];
        int s0, e0;
        exp_rec = '{10'h2FE, 10'h000, 10'h000, 10'h001, 10'h002, 10'h0CA, 10'h06F};
        rec_q.delete();
        s0 = sync_cnt; e0 = err_cnt;
        send_preamble(12);
        repeat (3) send_sync();
        send_byte(8'hFE); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h02); send_byte(8'hCA); send_byte(8'h6F);
        idle(3);
        checks++; if (sync_cnt - s0 !== 3) begin failures++; $display("FAIL normal_sync_pulses got %0d want 3", sync_cnt - s0); end
        checks++; if (rec_q.size() !== 7) begin failures++; $display("FAIL normal_byte_valids got %0d want 7", rec_q.size()); end
        for (int i = 0; i < 7 && i < rec_q.size(); i++) begin
            checks++;
            if (rec_q[i] !== exp_rec[i]) begin
                failures++; $display("FAIL normal_byte%0d got %0h want %0h", i, rec_q[i], exp_rec[i]);
            end
        end
        checks++; if (err_cnt - e0 !== 0) begin failures++; $display("FAIL normal_mfm_error got %0d want 0", err_cnt - e0); end
        checks++; if (byte_count !== 11'd7) begin failures++; $display("FAIL normal_byte_count got %0d want 7", byte_count); end
        checks++; if (in_sync !== 1'b1) begin failures++; $display("FAIL normal_in_sync got %0b want 1", in_sync); end
`ifdef MFM_CRC_EN
        checks++; if (crc_ok !== 1'b1) begin failures++; $display("FAIL normal_crc_ok got %0b (crc %0h) want 1", crc_ok, crc_value); end
`endif
    endtask

    task automatic test_short_sync();
        int b0, s0;
        do_resync();
        @(negedge clk);
        checks++; if (in_sync !== 1'b0) begin failures++; $display("FAIL short_resync_in_sync got %0b want 0", in_sync); end
        b0 = bv_cnt; s0 = sync_cnt;
        send_preamble(4);
        repeat (2) send_sync();
        send_byte(8'hFE);
        send_byte(8'h00);
        idle(3);
        checks++; if (sync_cnt - s0 !== 2) begin failures++; $display("FAIL short_sync_pulses got %0d want 2", sync_cnt - s0); end
        checks++; if (bv_cnt - b0 !== 0) begin failures++; $display("FAIL short_byte_valids got %0d want 0", bv_cnt - b0); end
        checks++; if (in_sync !== 1'b0) begin failures++; $display("FAIL short_in_sync got %0b want 0", in_sync); end
    endtask

    task automatic test_clock_violation();
        logic [9:0] exp_rec [3];
        exp_rec = '{10'h2FE, 10'h100, 10'h000};
        do_resync();
        rec_q.delete();
        send_preamble(4);
        repeat (3) send_sync();
        send_byte(8'hFE);
        send_word(mfm_enc(8'h00, tx_prev) ^ 16'h8000);
        tx_prev = 1'b0;
        send_byte(8'h00);
        idle(3);
        checks++; if (rec_q.size() !== 3) begin failures++; $display("FAIL clkerr_byte_valids got %0d want 3", rec_q.size()); end
        for (int i = 0; i < 3 && i < rec_q.size(); i++) begin
            checks++;
            if (rec_q[i] !== exp_rec[i]) begin
                failures++; $display("FAIL clkerr_byte%0d got %0h want %0h", i, rec_q[i], exp_rec[i]);
            end
        end
    endtask

    task automatic test_pll_unlock();
        logic [15:0] w;
        int b0;
        do_resync();
        rec_q.delete();
        send_preamble(4);
        repeat (3) send_sync();
        send_byte(8'hFE); send_byte(8'h00); send_byte(8'h01);
        w = mfm_enc(8'h02, tx_prev);
        tx_prev = 1'b0;
        for (int i = 15; i >= 1; i--) send_bit(w[i]);
        checks++; if (in_sync !== 1'b1) begin failures++; $display("FAIL pll_in_sync_before got %0b want 1", in_sync); end
        @(negedge clk);
        data_bit   = w[0];
        data_ready = 1'b1;
        pll_locked = 1'b0;
        @(negedge clk);
        data_ready = 1'b0;
        checks++; if (in_sync !== 1'b0) begin failures++; $display("FAIL pll_in_sync_after got %0b want 0", in_sync); end
        pll_locked = 1'b1;
        send_byte(8'hCA);
        send_byte(8'h6F);
        idle(3);
        checks++; if (rec_q.size() !== 3) begin failures++; $display("FAIL pll_byte_valids got %0d want 3", rec_q.size()); end
        checks++; if (in_sync !== 1'b0) begin failures++; $display("FAIL pll_in_sync_held got %0b want 0", in_sync); end
        b0 = bv_cnt;
        send_preamble(2);
        repeat (3) send_sync();
        send_byte(8'hFE);
        idle(3);
        checks++; if (bv_cnt - b0 !== 1) begin failures++; $display("FAIL pll_relock_valids got %0d want 1", bv_cnt - b0); end
        checks++; if (rec_q[rec_q.size()-1] !== 10'h2FE) begin
            failures++; $display("FAIL pll_relock_mark got %0h want 2fe", rec_q[rec_q.size()-1]);
        end
    endtask

    task automatic test_bound();
        int b0, bb0;
        do_resync();
        b0 = bv_cnt; bb0 = bv_cnt_b;
        send_preamble(4);
        repeat (3) send_sync();
        send_byte(8'hFE);
        for (int i = 0; i < 10; i++) send_byte(8'(i));
        idle(3);
        checks++; if (bv_cnt_b - bb0 !== 4) begin failures++; $display("FAIL bound_valids got %0d want 4", bv_cnt_b - bb0); end
        checks++; if (b_byte_count !== 11'd4) begin failures++; $display("FAIL bound_byte_count got %0d want 4", b_byte_count); end
        checks++; if (b_in_sync !== 1'b0) begin failures++; $display("FAIL bound_in_sync got %0b want 0", b_in_sync); end
        checks++; if (bv_cnt - b0 !== 11) begin failures++; $display("FAIL bound_main_valids got %0d want 11", bv_cnt - b0); end
        checks++; if (byte_count !== 11'd11) begin failures++; $display("FAIL bound_main_count got %0d want 11", byte_count); end
    endtask

    task automatic test_back_to_back();
        int s0;
        rec_q.delete();
        s0 = sync_cnt;
        repeat (3) send_sync();
        send_byte(8'hFE);
        send_byte(8'h00);
        idle(3);
        checks++; if (sync_cnt - s0 !== 3) begin failures++; $display("FAIL b2b_sync_pulses got %0d want 3", sync_cnt - s0); end
        checks++; if (rec_q.size() !== 2) begin failures++; $display("FAIL b2b_byte_valids got %0d want 2", rec_q.size()); end
        if (rec_q.size() > 0) begin
            checks++; if (rec_q[0] !== 10'h2FE) begin failures++; $display("FAIL b2b_mark got %0h want 2fe", rec_q[0]); end
        end
        checks++; if (byte_count !== 11'd2) begin failures++; $display("FAIL b2b_byte_count got %0d want 2", byte_count); end
        checks++; if (b_byte_count !== 11'd2) begin failures++; $display("FAIL b2b_hunt_count got %0d want 2", b_byte_count); end
    endtask

    initial begin
        test_reset();
        test_normal_field();
        test_short_sync();
        test_clock_violation();
        test_pll_unlock();
        test_bound();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
